// File: rtl/cpu_controller_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Desc    : States, opcode/ext fields, ALU codes, mux selects and the
//           ALU-class decoder shared by the CR16-subset control FSM.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_LATCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_ALU       = 4'd3,
        S_LOAD_ADDR = 4'd4,
        S_LOAD_WB   = 4'd5,
        S_STORE     = 4'd6,
        S_LUI       = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JAL       = 4'd10,
        S_NOP       = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_MEM    = 4'h4;
    localparam logic [3:0] OP_SHIFT  = 4'h8;
    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_LUI    = 4'hF;

    localparam logic [3:0] EXT_AND   = 4'h1;
    localparam logic [3:0] EXT_OR    = 4'h2;
    localparam logic [3:0] EXT_XOR   = 4'h3;
    localparam logic [3:0] EXT_ADD   = 4'h5;
    localparam logic [3:0] EXT_SUB   = 4'h9;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_MOV   = 4'hD;
    localparam logic [3:0] EXT_LSHI  = 4'h0;
    localparam logic [3:0] EXT_LSH   = 4'h4;
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_MOV = 4'd6;
    localparam logic [3:0] ALU_LSH = 4'd7;

    localparam logic [1:0] PCM_NEXT = 2'd0;
    localparam logic [1:0] PCM_RF   = 2'd1;
    localparam logic [1:0] PCM_ALU  = 2'd2;
    localparam logic [1:0] MAM_PC   = 2'd0;
    localparam logic [1:0] MAM_RF   = 2'd1;
    localparam logic [1:0] RWM_MEM  = 2'd0;
    localparam logic [1:0] RWM_LINK = 2'd1;
    localparam logic [1:0] RWM_MOV  = 2'd2;
    localparam logic [1:0] RWM_LUI  = 2'd3;
    localparam logic [1:0] A2M_RF   = 2'd0;
    localparam logic [1:0] A2M_IMM4 = 2'd1;
    localparam logic [1:0] A2M_SEXT = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] a2m;
        logic [3:0] alu;
        logic       setflags;
        logic       wr_rf;
        logic       movm;
    } alu_dec_t;

    // Register forms carry the function in ext; immediate forms reuse it as op.
    function automatic alu_dec_t alu_decode(input logic [3:0] op, input logic [3:0] ext);
        alu_dec_t   d;
        logic [3:0] code;
        d    = '{valid: 1'b0, a2m: A2M_RF, alu: ALU_ADD, setflags: 1'b0, wr_rf: 1'b0, movm: 1'b1};
        code = (op == OP_RTYPE) ? ext : op;
        if (op == OP_SHIFT) begin
            d.alu   = ALU_LSH;
            d.wr_rf = 1'b1;
            if (ext == EXT_LSH) begin
                d.valid = 1'b1;
            end else if (ext == EXT_LSHI) begin
                d.valid = 1'b1;
                d.a2m   = A2M_IMM4;
            end
        end else begin
            if (op != OP_RTYPE) d.a2m = A2M_SEXT;
            case (code)
                EXT_ADD: begin d.valid = 1'b1; d.wr_rf = 1'b1; d.setflags = 1'b1; d.alu = ALU_ADD; end
                EXT_SUB: begin d.valid = 1'b1; d.wr_rf = 1'b1; d.setflags = 1'b1; d.alu = ALU_SUB; end
                EXT_CMP: begin d.valid = 1'b1; d.setflags = 1'b1; d.alu = ALU_CMP; end
                EXT_AND: begin d.valid = 1'b1; d.wr_rf = 1'b1; d.alu = ALU_AND; end
                EXT_OR:  begin d.valid = 1'b1; d.wr_rf = 1'b1; d.alu = ALU_OR;  end
                EXT_XOR: begin d.valid = 1'b1; d.wr_rf = 1'b1; d.alu = ALU_XOR; end
                EXT_MOV: begin d.valid = 1'b1; d.wr_rf = 1'b1; d.alu = ALU_MOV; d.movm = 1'b0; end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_controller_if.sv
// ============================================================================
// Module  : cpu_controller_if
// Desc    : Controller <-> datapath bundle: IR/PSR in, enables/selects out.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_controller_if #(parameter int SIZE = 16);
    logic [SIZE-1:0] instr;
    logic [1:0]      flags1out;
    logic [2:0]      flags2out;
    logic            MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen;
    logic            Movm, A1m, setZNL;
    logic [1:0]      PCm, MAm, A2m, RWm;
    logic [3:0]      aluOp;
    logic            instrDone;

    modport master (
        input  instr, flags1out, flags2out,
        output MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen,
        output Movm, A1m, setZNL, PCm, MAm, A2m, RWm, aluOp, instrDone
    );

    modport slave (
        output instr, flags1out, flags2out,
        input  MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen,
        input  Movm, A1m, setZNL, PCm, MAm, A2m, RWm, aluOp, instrDone
    );
endinterface

`default_nettype wire

// File: rtl/cpu_controller_cond_eval.sv
// ============================================================================
// Module  : cond_eval
// Desc    : Branch/jump condition evaluator over PSR {C,F} and {Z,N,L}.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval (
    input  wire logic [3:0] cond,
    input  wire logic [1:0] flags1,
    input  wire logic [2:0] flags2,
    output logic            taken
);
    logic w_c, w_f, w_z, w_n, w_l;
    assign {w_c, w_f}      = flags1;
    assign {w_z, w_n, w_l} = flags2;

    always_comb begin
        taken = 1'b0;
        case (cond)
            4'h0: taken = w_z;
            4'h1: taken = ~w_z;
            4'h2: taken = w_c;
            4'h3: taken = ~w_c;
            4'h4: taken = w_l;
            4'h5: taken = ~w_l;
            4'h6: taken = w_n;
            4'h7: taken = ~w_n;
            4'h8: taken = w_f;
            4'h9: taken = ~w_f;
            4'hA: taken = ~w_l & ~w_z;
            4'hB: taken = w_l | w_z;
            4'hC: taken = ~w_n & ~w_z;
            4'hD: taken = w_n | w_z;
            4'hE: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module  : cpu_controller
// Desc    : Multi-cycle control FSM for the 16-bit CR16-subset datapath.
//           Optional single-step control under macro CPU_CTRL_STEP_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
`ifdef CPU_CTRL_STEP_EN
    input  wire logic          run,
    input  wire logic          step,
`endif
    cpu_controller_if.master   bus
);
    state_t          r_state, w_next;
    logic [SIZE-1:0] w_instr;
    logic [3:0]      w_op, w_ext, w_cond;
    logic            w_taken, w_advance;
    alu_dec_t        w_dec;
    logic            w_unused;

    assign w_instr  = bus.instr;
    assign w_op     = w_instr[15:12];
    assign w_cond   = w_instr[11:8];
    assign w_ext    = w_instr[7:4];
    assign w_dec    = alu_decode(w_op, w_ext);
    assign w_unused = ^w_instr[3:0];

    cond_eval u_cond_eval (
        .cond   (w_cond),
        .flags1 (bus.flags1out),
        .flags2 (bus.flags2out),
        .taken  (w_taken)
    );

`ifdef CPU_CTRL_STEP_EN
    logic r_step_d, r_step_go;

    // A step edge is latched and consumed by the next S_FETCH, so an edge seen mid-instruction still counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_d  <= 1'b0;
            r_step_go <= 1'b0;
        end else begin
            r_step_d <= step;
            if (step && !r_step_d)
                r_step_go <= 1'b1;
            else if (r_state == S_FETCH)
                r_step_go <= 1'b0;
        end
    end

    assign w_advance = run | r_step_go;
`else
    assign w_advance = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (w_advance) w_next = S_LATCH;
            S_LATCH:     w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LUI:   w_next = S_LUI;
                    OP_BCOND: w_next = S_BRANCH;
                    OP_MEM: begin
                        case (w_ext)
                            EXT_LOAD:  w_next = S_LOAD_ADDR;
                            EXT_STOR:  w_next = S_STORE;
                            EXT_JAL:   w_next = S_JAL;
                            EXT_JCOND: w_next = S_JUMP;
                            default:   w_next = S_NOP;
                        endcase
                    end
                    default:  w_next = w_dec.valid ? S_ALU : S_NOP;
                endcase
            end
            S_LOAD_ADDR: w_next = S_LOAD_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.MemW1en   = 1'b0;
        bus.MemW2en   = 1'b0;
        bus.RFen      = 1'b0;
        bus.PSRen     = 1'b0;
        bus.PCen      = 1'b0;
        bus.INSTRen   = 1'b0;
        bus.Movm      = 1'b0;
        bus.A1m       = 1'b0;
        bus.setZNL    = 1'b0;
        bus.PCm       = PCM_NEXT;
        bus.MAm       = MAM_PC;
        bus.A2m       = A2M_RF;
        bus.RWm       = RWM_MEM;
        bus.aluOp     = ALU_ADD;
        bus.instrDone = 1'b0;
        case (r_state)
            S_LATCH:     bus.INSTRen = 1'b1;
            S_ALU: begin
                bus.RFen      = w_dec.wr_rf;
                bus.Movm      = w_dec.movm;
                bus.A2m       = w_dec.a2m;
                bus.aluOp     = w_dec.alu;
                bus.PSRen     = w_dec.setflags;
                bus.setZNL    = w_dec.setflags;
                bus.RWm       = RWM_MOV;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_LOAD_ADDR: bus.MAm = MAM_RF;
            S_LOAD_WB: begin
                bus.MAm       = MAM_RF;
                bus.RWm       = RWM_MEM;
                bus.RFen      = 1'b1;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_STORE: begin
                bus.MAm       = MAM_RF;
                bus.MemW1en   = 1'b1;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_LUI: begin
                bus.RWm       = RWM_LUI;
                bus.RFen      = 1'b1;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_BRANCH: begin
                // Taken target is PC + sext(disp) computed by the ALU.
                if (w_taken) begin
                    bus.A1m = 1'b1;
                    bus.A2m = A2M_SEXT;
                    bus.PCm = PCM_ALU;
                end
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_JUMP: begin
                bus.PCm       = w_taken ? PCM_RF : PCM_NEXT;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_JAL: begin
                bus.RWm       = RWM_LINK;
                bus.RFen      = 1'b1;
                bus.PCm       = PCM_RF;
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            S_NOP: begin
                bus.PCen      = 1'b1;
                bus.instrDone = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire
